// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store sequencer (IDLE -> REQ -> WAIT -> DONE).
// Define DMEM_TIMEOUT_EN to add a bus-timeout watchdog that ends stuck accesses with bus_err_o.
package core;
  typedef enum logic [3:0] {
    MEM_NOP = 4'b0000,
    SB      = 4'b0001,
    SH      = 4'b0010,
    SW      = 4'b0011,
    LB      = 4'b1001,
    LH      = 4'b1010,
    LW      = 4'b1011,
    LBU     = 4'b1101,
    LHU     = 4'b1110
  } mem_op_t;
endpackage

module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  input  core::mem_op_t mem_op_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic         stall_o,
  output logic         done_o,
  output logic [31:0]  rd_res_o,
  output logic         misaligned_o,
  output logic         bus_err_o,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output logic [3:0]   dmem_be_o,
  output logic [31:0]  dmem_addr_o,
  output logic [31:0]  dmem_wdata_o,
  input  logic         dmem_gnt_i,
  input  logic         dmem_rvalid_i,
  input  logic [31:0]  dmem_rdata_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  core::mem_op_t op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_res_q, rd_res_d;
  logic          mis_q, mis_d;

  logic          accept;
  logic          timeout;
  logic          in_mis;
  logic [3:0]    op_in_bits;
  logic [3:0]    op_bits;
  logic [31:0]   lane;
  logic [31:0]   load_val;

  // op encoding: [3] load, [2] zero-extend, [1:0] size (01 byte, 10 half, 11 word)
  assign op_in_bits = mem_op_i;
  assign op_bits    = op_q;

  always_comb begin
    in_mis = 1'b0;
    if (op_in_bits[1:0] == 2'b10)      in_mis = addr_i[0];
    else if (op_in_bits[1:0] == 2'b11) in_mis = (addr_i[1:0] != 2'b00);
  end

  assign lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = dmem_rdata_i;
    case (op_q)
      core::LB:  load_val = {{24{lane[7]}}, lane[7:0]};
      core::LBU: load_val = {24'h0, lane[7:0]};
      core::LH:  load_val = {{16{lane[15]}}, lane[15:0]};
      core::LHU: load_val = {16'h0, lane[15:0]};
      default:   load_val = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= core::MEM_NOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_res_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_res_q <= rd_res_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_res_d = rd_res_q;
    mis_d    = mis_q;
    stall_o  = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && (mem_op_i != core::MEM_NOP)) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          op_d    = mem_op_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          mis_d   = in_mis;
          state_d = in_mis ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i)   state_d = op_bits[3] ? S_WAIT : S_DONE;
        else if (timeout) state_d = S_DONE;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          rd_res_d = load_val;
          state_d  = S_DONE;
        end else if (timeout) begin
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        mis_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;

  // cycles in REQ and WAIT share one budget; saturate so a late grant cannot wrap it
  assign timeout = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    berr_d = berr_q;
    if (accept) begin
      cnt_d  = '0;
      berr_d = 1'b0;
    end else if (state_q == S_DONE) begin
      berr_d = 1'b0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (((state_q == S_REQ) && !dmem_gnt_i && timeout) ||
          ((state_q == S_WAIT) && !dmem_rvalid_i && timeout))
        berr_d = 1'b1;
    end
  end

  assign bus_err_o = berr_q;
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  assign done_o       = (state_q == S_DONE);
  assign misaligned_o = mis_q;
  assign rd_res_o     = rd_res_q;
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = (op_q != core::MEM_NOP) && !op_bits[3];
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = wdata_q;
    unique case (op_bits[1:0])
      2'b01: begin
        dmem_be_o    = 4'b0001 << addr_q[1:0];
        dmem_wdata_o = {4{wdata_q[7:0]}};
      end
      2'b10: begin
        dmem_be_o    = 4'b0011 << addr_q[1:0];
        dmem_wdata_o = {2{wdata_q[15:0]}};
      end
      2'b11:   dmem_be_o = 4'b1111;
      default: dmem_be_o = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vectors plus randomized accesses
// compared against a cycle-count/arithmetic reference model.
module tb_dmem_access_ctrl;
  import core::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  mem_op_t     mem_op;
  logic [31:0] addr, wdata;
  logic        stall, done, mis, berr;
  logic [31:0] rd_res;
  logic        dreq, dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr, dwdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_rd = '0;
  mem_op_t ops[8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .mem_op_i(mem_op),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
    .rd_res_o(rd_res), .misaligned_o(mis), .bus_err_o(berr),
    .dmem_req_o(dreq), .dmem_we_o(dwe), .dmem_be_o(dbe), .dmem_addr_o(daddr),
    .dmem_wdata_o(dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_size(input mem_op_t op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_load(input mem_op_t op);
    return (op == LB || op == LH || op == LW || op == LBU || op == LHU);
  endfunction

  function automatic bit is_mis(input mem_op_t op, input logic [31:0] a);
    int off = int'(a % 4);
    if (op_size(op) == 2) return (off % 2) != 0;
    if (op_size(op) == 4) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input mem_op_t op, input logic [31:0] a);
    int off = int'(a % 4);
    if (op_size(op) == 1) return 4'(1 << off);
    if (op_size(op) == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input mem_op_t op, input logic [31:0] w);
    if (op_size(op) == 1) return (w % 256) * 32'h0101_0101;
    if (op_size(op) == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] sh = d / (32'd1 << (8 * (a % 4)));
    logic [31:0] b = sh % 256;
    logic [31:0] h = sh % 65536;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return d;
    endcase
  endfunction

  // Starts in IDLE at posedge+1; returns in IDLE at posedge+1 one cycle after done.
  task automatic do_access(input mem_op_t op, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] rdat, input int gd, input int rd);
    bit ld = is_load(op);
    bit ms = is_mis(op, a);
    int req_last  = gd + 2;
    int wait_last = gd + 3 + rd;
    int exp_done  = ms ? 2 : (ld ? wait_last + 1 : req_last + 1);
    bit in_req, in_wait;
    if (ld && !ms) m_rd = exp_ld(op, a, rdat);
    req_valid = 1'b1; mem_op = op; addr = a; wdata = w;
    gnt = 1'b0; rvalid = 1'($urandom_range(1, 0)); rdata = $urandom;
    #1 check_eq("stall_idle", 32'(stall), 32'd1);
    for (int cyc = 2; cyc <= exp_done + 1; cyc++) begin
      @(posedge clk); #1;
      in_req  = !ms && cyc >= 2 && cyc <= req_last;
      in_wait = !ms && ld && cyc > req_last && cyc <= wait_last;
      check_eq("done", 32'(done), 32'(cyc == exp_done));
      check_eq("dmem_req", 32'(dreq), 32'(in_req));
      check_eq("stall", 32'(stall), 32'(in_req || in_wait));
      if (in_req) begin
        check_eq("dmem_addr", daddr, a - (a % 4));
        check_eq("dmem_be", 32'(dbe), 32'(exp_be(op, a)));
        check_eq("dmem_we", 32'(dwe), 32'(!ld));
        if (!ld) check_eq("dmem_wdata", dwdata, exp_wd(op, w));
      end
      if (cyc == exp_done) begin
        check_eq("misaligned", 32'(mis), 32'(ms));
        check_eq("bus_err", 32'(berr), 32'd0);
      end
      if (cyc >= exp_done) check_eq("rd_res", rd_res, m_rd);
      gnt    = in_req && (cyc == req_last);
      rvalid = in_wait ? (cyc == wait_last) : 1'($urandom_range(1, 0));
      rdata  = (in_wait && cyc == wait_last) ? rdat : $urandom;
      if (cyc >= exp_done) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'($urandom_range(1, 0));
        mem_op = ops[$urandom_range(7, 0)];
        addr = $urandom; wdata = $urandom;
      end
    end
    gnt = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    int to_cyc;
    bit seen;
    mem_op_t op;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; mem_op = MEM_NOP; addr = '0; wdata = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_res", rd_res, 32'd0);
    check_eq("rst_req", 32'(dreq), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_be", 32'(dbe), 32'd0);
    check_eq("rst_addr", daddr, 32'd0);
    check_eq("rst_wdata", dwdata, 32'd0);
    check_eq("rst_flags", {29'd0, dwe, mis, berr}, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(LB, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
    check_eq("lb_vec", rd_res, 32'hFFFF_FF80);
    do_access(SH, 32'h22, 32'h0000_ABCD, 32'h0, 0, 0);
    do_access(LW, 32'h41, 32'h0, 32'h0, 0, 0);
    do_access(LHU, 32'h0, 32'h0, 32'h0000_9ABC, 5, 1);
    check_eq("lhu_vec", rd_res, 32'h0000_9ABC);
    do_access(SW, 32'h44, 32'hDEAD_BEEF, 32'h0, 2, 0);
    do_access(LH, 32'h46, 32'h0, 32'h8001_7FFF, 1, 3);
    do_access(SB, 32'h7, 32'h1234_56A5, 32'h0, 0, 0);
    do_access(LBU, 32'h2, 32'h0, 32'h00F1_0000, 0, 2);

    for (int t = 0; t < 60; t++) begin
      op = ops[$urandom_range(7, 0)];
      a = $urandom;
      if ($urandom_range(3, 0) != 0) a = a & 32'hFFFF_FFFC | 32'(op_size(op) == 1 ? $urandom_range(3, 0) : 0);
      do_access(op, a, $urandom, $urandom, $urandom_range(4, 0), $urandom_range(4, 0));
    end

    // reset while waiting for read data; late rvalid must not complete anything
    req_valid = 1'b1; mem_op = LB; addr = 32'h103; wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    check_eq("rstw_in_wait", {30'd0, stall, dreq}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h80FF_1234;
    m_rd = '0;
    check_eq("rstw_done0", 32'(done), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("rstw_done", 32'(done), 32'd0);
      check_eq("rstw_rd_res", rd_res, 32'd0);
      check_eq("rstw_idle", {30'd0, stall, dreq}, 32'd0);
      @(posedge clk); #1;
    end
    do_access(SW, 32'h10, 32'h5A5A_0F0F, 32'h0, 0, 0);

    // grant never arrives
    req_valid = 1'b1; mem_op = LW; addr = 32'h80; wdata = '0; gnt = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    to_cyc = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        if (dreq) to_cyc++;
        @(posedge clk); #1;
      end
    end
    check_eq("to_done_seen", 32'(seen), 32'd1);
    check_eq("to_req_cycles", 32'(to_cyc), 32'd16);
    check_eq("to_bus_err", 32'(berr), 32'd1);
    check_eq("to_req_low", 32'(dreq), 32'd0);
    check_eq("to_rd_res", rd_res, m_rd);
    @(posedge clk); #1;
`else
    to_cyc = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen = 1'b1;
      if (stall && dreq && !berr) to_cyc++;
      @(posedge clk); #1;
    end
    check_eq("nto_no_done", 32'(seen), 32'd0);
    check_eq("nto_stuck_cycles", 32'(to_cyc), 32'd40);
    check_eq("nto_bus_err", 32'(berr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_rd = '0;
`endif
    do_access(LBU, 32'h81, 32'h0, 32'h0000_C300, 0, 0);
    check_eq("final_rd_res", rd_res, 32'h0000_00C3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the max cycles spent in REQ+WAIT before a bus error (used only with DMEM_TIMEOUT_EN).
REQ-002 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-004 req_valid_i  in  1  SHALL indicate that the MEM-stage instruction carries a memory op.
REQ-005 mem_op_i  in  core::mem_op_t  SHALL carry the op: LB/LH/LW/LBU/LHU/SB/SH/SW/MEM_NOP, LOAD_PRFX in the MSB.
REQ-006 addr_i  in  32  SHALL carry the byte address; wdata_i  in  32  SHALL carry the store data (rs2_data).
REQ-007 stall_o  out  1  SHALL request a pipeline stall.
REQ-008 done_o  out  1  SHALL pulse for one cycle when an access completes.
REQ-009 rd_res_o  out  32  SHALL carry the extended load result.
REQ-010 misaligned_o  out  1  and  bus_err_o  out  1  SHALL flag the respective error, valid with done_o.
REQ-011 dmem_req_o  out  1, dmem_we_o  out  1, dmem_be_o  out  4, dmem_addr_o  out  32, dmem_wdata_o  out  32  SHALL drive the memory request.
REQ-012 dmem_gnt_i  in  1, dmem_rvalid_i  in  1, dmem_rdata_i  in  32  SHALL be the memory grant, read-valid and read data.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-014 IDLE: on req_valid_i with mem_op_i != MEM_NOP, the block SHALL latch the op, address and data and go to REQ next cycle; if the access is misaligned, it SHALL go to DONE instead.
REQ-015 Misaligned SHALL mean LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; LB/LBU/SB are never misaligned.
REQ-016 stall_o SHALL be combinationally 1 in IDLE when a valid non-NOP op is presented, 1 in REQ and WAIT, and 0 in DONE.
REQ-017 REQ: dmem_req_o SHALL be held at 1 with stable addr/we/be/wdata until dmem_gnt_i=1; on grant, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-018 dmem_addr_o SHALL be the latched address with bits [1:0] forced to 0.
REQ-019 dmem_be_o SHALL be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-020 dmem_wdata_o SHALL be the byte replicated x4 for SB, the half replicated x2 for SH, and the full word for SW.
REQ-021 dmem_rvalid_i SHALL be ignored outside WAIT.
REQ-022 WAIT: on dmem_rvalid_i, the block SHALL capture the lane selected by addr[1:0] into rd_res_o: LB/LH sign-extended, LBU/LHU zero-extended, LW unmodified; it SHALL then go to DONE.
REQ-023 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; rd_res_o SHALL hold until the next load captures.
REQ-024 A store or misaligned access SHALL leave rd_res_o unchanged.
REQ-025 Minimum latency, zero-wait memory: store 3 cycles (IDLE, REQ, DONE); load 4 cycles.
REQ-026 Inputs presented while not in IDLE SHALL be ignored; the pipeline keeps them stable via stall_o.

Reset
REQ-027 On rst_i=1 the FSM SHALL enter IDLE, and all outputs and latches SHALL be 0 next cycle, including rd_res_o=0 and dmem_req_o=0.
REQ-028 Reset mid-access SHALL abandon the request with no done_o pulse; any grant or rvalid arriving afterwards SHALL be ignored.

Configuration
REQ-029 With DMEM_TIMEOUT_EN defined, a counter SHALL clear on leaving IDLE and increment each cycle in REQ/WAIT.
REQ-030 With DMEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL force DONE with bus_err_o=1, dmem_req_o=0 and rd_res_o unchanged.
REQ-031 Without DMEM_TIMEOUT_EN, no counter SHALL exist, bus_err_o SHALL be tied to 0, and REQ/WAIT SHALL wait indefinitely.

Verification
REQ-032 LB at addr 0x103, rdata 0x80FF_1234, gnt and rvalid immediate -> rd_res_o=0xFFFF_FF80, be=0001->1000 lane, done_o in cycle 4.
REQ-033 SH at addr 0x22, wdata 0x0000_ABCD -> dmem_be_o=4'b1100, dmem_wdata_o=0xABCD_ABCD, dmem_addr_o=0x20, done_o in cycle 3.
REQ-034 LW at addr 0x41 -> misaligned_o=1 with done_o, dmem_req_o never asserted, rd_res_o unchanged.
REQ-035 LHU at 0x0, gnt delayed 5 cycles, rvalid 2 cycles later, rdata 0x0000_9ABC -> dmem_req_o held stable 6 cycles, stall_o high throughout, rd_res_o=0x0000_9ABC.
REQ-036 rst_i asserted in WAIT, rvalid the following cycle -> no done_o pulse, rd_res_o=0, FSM in IDLE.
REQ-037 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted -> bus_err_o=1 with done_o after 16 REQ cycles; without the macro, stall persists with bus_err_o=0.
